if_id_stage: RTL and testbench

Pipeline register and hazard-control stage directly downstream of the instruction fetch unit. Captures the fetched instruction and its PC+4 each cycle, presents them to decode, and detects load-use hazards against the ID/EX stage. On a hazard it freezes fetch and itself and inserts one bubble; on a taken jump or branch it flushes to a NOP. Its `PCWrite` output drives the fetch unit's `PCWrite` input, and `Bubble` selects zeroed control words in decode.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/load_use_detect.sv | 27 ++
 rtl/if_id_stage.sv | 115 +++++++++++
 tb/tb_if_id_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the IF/ID stage: opcodes, the NOP encoding,
// the IF/ID state encoding and the "instruction reads rt" helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2
  } if_id_state_e;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic op_uses_rt(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check of a decoded instruction against the
// load sitting in ID/EX. Shared with the forwarding unit.
module load_use_detect
  import mips_pkg::*;
(
  input  logic [31:0] Instruction,
  input  logic        Valid,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  output logic        LU
);

  logic [5:0] op_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       unused_s;

  assign op_s     = Instruction[31:26];
  assign rs_s     = Instruction[25:21];
  assign rt_s     = Instruction[20:16];
  assign unused_s = ^Instruction[15:0];

  // $0 is never a real dependency, so a load into it cannot stall.
  assign LU = Valid & IDEX_MemRead & (IDEX_Rt != 5'd0) &
              ((IDEX_Rt == rs_s) | (op_uses_rt(op_s) & (IDEX_Rt == rt_s)));

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, external hold and flush
// control, plus saturating stall/flush performance counters.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      InstructionIn,
  input  logic [31:0]      PCNext4In,
  input  logic             Flush,
  input  logic             ExtStall,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rt,
  output logic [31:0]      Instruction,
  output logic [31:0]      PCNext4,
  output logic             Valid,
  output logic             PCWrite,
  output logic             Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  if_id_state_e     st_q, st_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_raw_s;
  logic lu_s;
  logic occupied_s;
  logic hold_s;

  load_use_detect u_load_use_detect (
    .Instruction  (instr_q),
    .Valid        (valid_q),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_Rt      (IDEX_Rt),
    .LU           (lu_raw_s)
  );

  always_comb begin
    case (st_q)
      RUN, HOLD: occupied_s = 1'b1;
      default:   occupied_s = 1'b0;
    endcase
  end

  assign lu_s    = lu_raw_s & occupied_s;
  assign hold_s  = occupied_s & (ExtStall | lu_s);
  assign PCWrite = Flush | ~hold_s;
  assign Bubble  = ~Flush & ~ExtStall & lu_s;

  // An empty stage has nothing to protect, so it always loads unless flushed.
  always_comb begin
    st_d        = st_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Flush) begin
      st_d    = EMPTY;
      instr_d = NOP_WORD;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end else if (hold_s) begin
      st_d = HOLD;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      st_d    = RUN;
      instr_d = InstructionIn;
      pc4_d   = PCNext4In;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      st_q        <= EMPTY;
      instr_q     <= NOP_WORD;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Instruction = instr_q;
  assign PCNext4     = pc4_q;
  assign Valid       = valid_q;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized and directed bench for if_id_stage against a behavioural model
// of an "occupied or empty" pipeline slot; two instances cover CNT_W 16 and 4.
module tb_if_id_stage;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] InstructionIn = 32'h0;
  logic [31:0] PCNext4In = 32'h0;
  logic        Flush = 1'b0;
  logic        ExtStall = 1'b0;
  logic        IDEX_MemRead = 1'b0;
  logic [4:0]  IDEX_Rt = 5'd0;

  logic [31:0] a_instr, a_pc, b_instr, b_pc;
  logic        a_valid, a_pcw, a_bub, b_valid, b_pcw, b_bub;
  logic [15:0] a_stall, a_flush;
  logic [3:0]  b_stall, b_flush;

  always #5 Clk = ~Clk;

  if_id_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .InstructionIn(InstructionIn), .PCNext4In(PCNext4In),
    .Flush(Flush), .ExtStall(ExtStall), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .Instruction(a_instr), .PCNext4(a_pc), .Valid(a_valid), .PCWrite(a_pcw),
    .Bubble(a_bub), .StallCount(a_stall), .FlushCount(a_flush));

  if_id_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .InstructionIn(InstructionIn), .PCNext4In(PCNext4In),
    .Flush(Flush), .ExtStall(ExtStall), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .Instruction(b_instr), .PCNext4(b_pc), .Valid(b_valid), .PCWrite(b_pcw),
    .Bubble(b_bub), .StallCount(b_stall), .FlushCount(b_flush));

  int total = 0;
  int bad   = 0;

  // Model: the slot either holds a real instruction or is empty.
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  bit          m_valid = 1'b0;
  int          m_stall = 0;
  int          m_flush = 0;
  bit          m_ok = 1'b0;

  function automatic bit reads_rt(input logic [5:0] op);
    return op == 6'h00 || op == 6'h04 || op == 6'h05 ||
           op == 6'h28 || op == 6'h29 || op == 6'h2B;
  endfunction

  function automatic bit model_lu();
    logic [5:0] op;
    logic [4:0] rs, rt;
    op = m_instr[31:26];
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    return m_valid && IDEX_MemRead && IDEX_Rt != 5'd0 &&
           (IDEX_Rt == rs || (reads_rt(op) && IDEX_Rt == rt));
  endfunction

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  always @(posedge Clk) begin
    if (!Reset) begin
      m_instr <= 32'h0; m_pc <= 32'h0; m_valid <= 1'b0;
      m_stall <= 0; m_flush <= 0; m_ok <= 1'b1;
    end else if (m_ok) begin
      if (Flush) begin
        m_instr <= 32'h0; m_pc <= 32'h0; m_valid <= 1'b0; m_flush <= m_flush + 1;
      end else if (m_valid && (ExtStall || model_lu())) begin
        m_stall <= m_stall + 1;
      end else begin
        m_instr <= InstructionIn; m_pc <= PCNext4In; m_valid <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model every cycle once reset has been seen.
  always @(negedge Clk) begin
    bit lu, pcw, bub;
    if (m_ok) begin
      lu  = model_lu();
      pcw = Flush || !(m_valid && (ExtStall || lu));
      bub = !Flush && !ExtStall && lu;
      chk("instr16", a_instr, m_instr);
      chk("pc16", a_pc, m_pc);
      chk("valid16", 32'(a_valid), 32'(m_valid));
      chk("pcwrite16", 32'(a_pcw), 32'(pcw));
      chk("bubble16", 32'(a_bub), 32'(bub));
      chk("stall16", 32'(a_stall), sat(m_stall, 65535));
      chk("flush16", 32'(a_flush), sat(m_flush, 65535));
      chk("instr4", b_instr, m_instr);
      chk("pc4", b_pc, m_pc);
      chk("valid4", 32'(b_valid), 32'(m_valid));
      chk("pcwrite4", 32'(b_pcw), 32'(pcw));
      chk("bubble4", 32'(b_bub), 32'(bub));
      chk("stall4", 32'(b_stall), sat(m_stall, 15));
      chk("flush4", 32'(b_flush), sat(m_flush, 15));
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic ex, input logic mr, input logic [4:0] rt);
    InstructionIn = ins; PCNext4In = pc; Flush = fl; ExtStall = ex;
    IDEX_MemRead = mr; IDEX_Rt = rt;
    #1;
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  logic [5:0] ops [8] = '{6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B, 6'h08, 6'h23};

  initial begin
    Reset = 1'b0;
    step(); step();
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_pcwrite", 32'(a_pcw), 32'h1);
    chk("rst_stall", 32'(a_stall), 32'h0);
    chk("rst_flush", 32'(a_flush), 32'h0);

    Reset = 1'b1;
    drive(32'h2008_0005, 32'h4, 1'b0, 1'b0, 1'b0, 5'd0); step();
    chk("first_valid", 32'(a_valid), 32'h1);
    chk("first_instr", a_instr, 32'h2008_0005);

    drive(32'h0109_5020, 32'h8, 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(32'h2008_0005, 32'hC, 1'b0, 1'b0, 1'b1, 5'd8);
    chk("lu_pcwrite", 32'(a_pcw), 32'h0);
    chk("lu_bubble", 32'(a_bub), 32'h1);
    step();
    chk("lu_held", a_instr, 32'h0109_5020);
    chk("lu_stall", 32'(a_stall), 32'h1);
    drive(32'h2008_0005, 32'hC, 1'b0, 1'b0, 1'b0, 5'd8);
    chk("lu_release_pcw", 32'(a_pcw), 32'h1);
    chk("lu_release_bub", 32'(a_bub), 32'h0);
    step();
    chk("lu_resume", a_instr, 32'h2008_0005);

    drive(32'h2109_0007, 32'h10, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("zero_rt_nostall", 32'(a_pcw), 32'h1);
    drive(32'h2109_0007, 32'h10, 1'b0, 1'b0, 1'b1, 5'd8);
    chk("addi_rt_nostall", 32'(a_pcw), 32'h1);
    drive(32'h2109_0007, 32'h10, 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(32'h0000_0000, 32'h14, 1'b0, 1'b0, 1'b1, 5'd9);
    chk("addi_rt9_nostall", 32'(a_pcw), 32'h1);
    drive(32'h0000_0000, 32'h14, 1'b0, 1'b0, 1'b1, 5'd8);
    chk("addi_rs_stall", 32'(a_pcw), 32'h0);
    chk("addi_rs_bubble", 32'(a_bub), 32'h1);

    drive(32'h0000_0000, 32'h14, 1'b1, 1'b0, 1'b1, 5'd8);
    chk("flush_lu_pcw", 32'(a_pcw), 32'h1);
    chk("flush_lu_bub", 32'(a_bub), 32'h0);
    step();
    chk("flush_lu_instr", a_instr, 32'h0);
    chk("flush_lu_valid", 32'(a_valid), 32'h0);
    chk("flush_lu_fcnt", 32'(a_flush), 32'h1);
    chk("flush_lu_scnt", 32'(a_stall), 32'h1);

    drive(32'h0109_5020, 32'h18, 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(32'h0109_5020, 32'h18, 1'b1, 1'b1, 1'b0, 5'd0);
    chk("flush_ext_pcw", 32'(a_pcw), 32'h1);
    step();
    chk("flush_ext_valid", 32'(a_valid), 32'h0);
    chk("flush_ext_fcnt", 32'(a_flush), 32'h2);
    chk("flush_ext_scnt", 32'(a_stall), 32'h1);

    drive(32'h8C08_0000, 32'h1C, 1'b0, 1'b0, 1'b0, 5'd0); step();
    for (int i = 0; i < 5; i++) begin
      drive(32'h0109_5020, 32'h20, 1'b0, 1'b1, 1'b0, 5'd0);
      chk("ext_pcw", 32'(a_pcw), 32'h0);
      chk("ext_bub", 32'(a_bub), 32'h0);
      step();
      chk("ext_held", a_instr, 32'h8C08_0000);
    end
    chk("ext_stall5", 32'(a_stall), 32'h6);
    drive(32'h0109_5020, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0); step();
    chk("ext_resume", a_instr, 32'h0109_5020);

    for (int i = 0; i < 20; i++) begin
      drive(32'h1234_5678, 32'h24, 1'b0, 1'b1, 1'b0, 5'd0); step();
    end
    chk("sat4_stall", 32'(b_stall), 32'hF);
    chk("nosat16_stall", 32'(a_stall), 32'd26);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             16'($urandom)};
      Reset = ($urandom_range(0, 199) != 0);
      drive(ins, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
      step();
    end

    Reset = 1'b0;
    step();
    chk("final_rst_stall", 32'(a_stall), 32'h0);
    chk("final_rst_flush", 32'(b_flush), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
